fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Read-side engine for sync_fifo.
- Drives the FIFO's r_en and absorbs r_data/r_data_valid, which arrive one cycle after r_en.
- Re-presents the words, in order and without loss, on a valid/ready stream to a downstream consumer.
- Sits between any sync_fifo instance and a stream sink; an internal skid buffer sustains one word per cycle under back-pressure.

Parameters:
- WIDTH, 9, data word width in bits.
- SKID_DEPTH, 2, internal buffer entries. Legal minimum is 2. 2 gives full throughput with the 1-cycle FIFO read latency.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- enable  in  1  allows new FIFO reads while high.
- fifo_empty  in  1  FIFO empty flag; registered, reflects pops up to the previous edge.
- fifo_r_en  out  1  FIFO read request.
- fifo_r_data  in  WIDTH  FIFO read data; valid only with fifo_r_data_valid.
- fifo_r_data_valid  in  1  one-cycle pulse, the cycle after an accepted fifo_r_en.
- m_data  out  WIDTH  stream data, head of skid buffer.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- idle  out  1  high in IDLE with nothing buffered or in flight.
- err  out  1  sticky protocol error flag.
- stat_words  out  32  words delivered (see Optional Feature).
- stat_stalls  out  32  back-pressure cycles (see Optional Feature).

Behaviour:
Reset values:
- fifo_r_en=0, m_valid=0, m_data=0, idle=1, err=0, stats=0.
- Skid buffer count=0, inflight=0, state=IDLE.

Definitions:
- pop = m_valid && m_ready.
- count = buffered entries.
- inflight = 1 if fifo_r_en was high last cycle, else 0.

Read issue:
- fifo_r_en is combinational, high when all hold: state==RUN, !fifo_empty, and (count + inflight - pop) < SKID_DEPTH.
- fifo_r_en is never asserted while fifo_empty=1.

Capture and output:
- On fifo_r_data_valid, fifo_r_data is written to the buffer tail.
- Capture and pop in the same cycle are both performed; count is unchanged.
- m_valid = (count != 0); m_data = buffer head.
- Zero-cycle bypass is not allowed: minimum latency is fifo_r_en to m_valid = 2 cycles (r_data_valid at +1, registered into buffer, visible at +2).
- Buffer is a circular array with head/tail pointers wrapping modulo SKID_DEPTH.
- Order is strictly preserved.

State machine:
- IDLE: enable=1 -> RUN.
- RUN: enable=0 -> DRAIN.
- DRAIN: no new fifo_r_en. Deliver buffered and in-flight words. When count==0 and inflight==0: enable=1 -> RUN, otherwise -> IDLE.
- DRAIN with enable re-asserted before empty: stay in DRAIN until drained, then RUN.
- idle = (state==IDLE).

Error handling (err sets, sticky until rst):
- fifo_r_data_valid with inflight==0, or
- fifo_r_data_valid with buffer full and no pop.
- The offending word is dropped; all other behaviour is unchanged.

Boundaries:
- FIFO going empty mid-stream: fifo_r_en drops, m_valid drops once the buffer drains.
- m_ready held low: at most SKID_DEPTH words are buffered; fifo_r_en stays low.
- Reset mid-operation: buffer and inflight are discarded and any following r_data_valid is ignored.

Optional Feature:
FIFO_READER_STATS_EN
- Defined:
  - stat_words increments on each pop.
  - stat_stalls increments on each cycle with m_valid && !m_ready.
  - Both counters are 32-bit, wrap at 2^32, and clear on rst.
- Undefined: stat_words and stat_stalls are tied to 0 with no counter logic. Ports are always present.

Test Plan:
- Throughput: FIFO preloaded with 0x001..0x064 (100 words), enable=1, m_ready=1 -> words out in order, one per cycle after the 2-cycle fill, fifo_r_en continuously high until empty, err=0.
- Back-pressure: preload 4 words, m_ready=0 for 10 cycles, then 1 -> exactly 2 fifo_r_en pulses during the stall, m_data held at word 0, all 4 delivered in order, stat_stalls=10 with FIFO_READER_STATS_EN.
- Random: 100 random words written at random rate, m_ready random 50% -> output queue equals input queue, fifo_r_en never high with fifo_empty=1.
- Drain: enable dropped the cycle fifo_r_en is high -> in-flight word and buffer delivered, no further fifo_r_en, idle=1 once drained.
- Error: inject fifo_r_data_valid=1 with no prior fifo_r_en -> err=1 next cycle and stays high, word not presented on m_data; rst clears err.
- Reset mid-stream: rst asserted with count=2 and a read in flight -> next cycle m_valid=0, idle=1, and the late r_data_valid does not appear on the output.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read engine for sync_fifo: issues r_en, captures r_data one cycle later into a skid buffer, re-presents it on valid/ready (r_en to m_valid = 2 cycles).
// Back-pressure stops reads once buffered + in-flight words would exceed SKID_DEPTH; optional counters under FIFO_READER_STATS_EN.
module fifo_stream_reader #(
  parameter int WIDTH      = 9,
  parameter int SKID_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_r_en,
  input  logic [WIDTH-1:0] fifo_r_data,
  input  logic             fifo_r_data_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             idle,
  output logic             err,
  output logic [31:0]      stat_words,
  output logic [31:0]      stat_stalls
);

  localparam int PW = $clog2(SKID_DEPTH);
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C  = (CW+1)'(SKID_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(SKID_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             inflight_q;
  logic             drop_q;
  logic             err_q, err_d;
  logic             pop;
  logic             cap;
  logic             full;
  logic [CW:0]      occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    m_valid   = (count_q != '0);
    m_data    = mem_q[head_q];
    pop       = m_valid && m_ready;
    full      = ({1'b0, count_q} == DEPTH_C);
    occ       = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    fifo_r_en = (state_q == ST_RUN) && !fifo_empty && (occ < DEPTH_C);
    cap       = fifo_r_data_valid && inflight_q && (!full || pop);
    // drop_q marks the return of a read issued on the reset edge: discard silently
    err_d     = err_q || (fifo_r_data_valid && !drop_q && !cap);
    count_d   = count_q + CW'(cap) - CW'(pop);
    head_d    = pop ? ptr_inc(head_q) : head_q;
    tail_d    = cap ? ptr_inc(tail_q) : tail_q;
    idle      = (state_q == ST_IDLE);
    err       = err_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: if (count_q == '0 && !inflight_q) state_d = enable ? ST_RUN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      drop_q     <= fifo_r_en;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= fifo_r_en;
      drop_q     <= 1'b0;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
    end else if (cap) begin
      mem_q[tail_q] <= fifo_r_data;
    end
  end

`ifdef FIFO_READER_STATS_EN
  logic [31:0] words_q;
  logic [31:0] stalls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (pop) words_q <= words_q + 32'd1;
      if (m_valid && !m_ready) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign stat_words  = words_q;
  assign stat_stalls = stalls_q;
`else
  assign stat_words  = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model drives the read side, a word-level pipe model predicts the stream.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst, enable, fifo_empty, fifo_r_en, fifo_r_data_valid;
  logic        m_valid, m_ready, idle, err;
  logic [8:0]  fifo_r_data, m_data;
  logic [31:0] stat_words, stat_stalls;

  fifo_stream_reader #(.WIDTH(9), .SKID_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_r_en(fifo_r_en), .fifo_r_data(fifo_r_data),
    .fifo_r_data_valid(fifo_r_data_valid), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .idle(idle), .err(err),
    .stat_words(stat_words), .stat_stalls(stat_stalls)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] d;
    int         c;
  } ent_t;

  ent_t       pipe[$];
  logic [8:0] fq[$];
  logic [8:0] in_q[$];
  logic [8:0] out_q[$];

  int n_vec = 0, n_err = 0;
  int cyc = 0, ren_cnt = 0, first_ren = -1, last_ren = -1, first_vld = -1;
  int wr_left = 0;
  logic err_exp = 1'b0, inject_req = 1'b0, inj_cur = 1'b0;
  int words_m = 0, stalls_m = 0;
  logic s_ren, s_pop, s_rst, s_inj, s_vld, s_idle, s_err;
  logic [8:0] s_dat;
  logic [31:0] s_words, s_stalls;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    logic exp_vld;
    @(negedge clk);
    s_ren = fifo_r_en; s_pop = m_valid && m_ready; s_rst = rst;
    s_inj = fifo_r_data_valid && inj_cur;
    s_vld = m_valid; s_dat = m_data; s_idle = idle; s_err = err;
    s_words = stat_words; s_stalls = stat_stalls;
    exp_vld = (pipe.size() > 0) && (pipe[0].c + 2 <= cyc);
    if (!s_rst) begin
      chk("ren_while_empty", s_ren && fifo_empty, 0);
      chk("m_valid", s_vld, exp_vld);
      if (exp_vld) chk("m_data", s_dat, pipe[0].d);
      chk("err", s_err, err_exp);
      chk("occupancy", (pipe.size() - int'(s_pop) + int'(s_ren)) <= 2, 1);
`ifdef FIFO_READER_STATS_EN
      chk("stat_words", s_words, words_m);
      chk("stat_stalls", s_stalls, stalls_m);
`else
      chk("stat_words", s_words, 0);
      chk("stat_stalls", s_stalls, 0);
`endif
    end
    if (s_vld && first_vld < 0) first_vld = cyc;
    if (s_pop) begin
      words_m++;
      if (pipe.size() > 0) out_q.push_back(pipe.pop_front().d);
    end
    if (s_vld && !m_ready) stalls_m++;
    if (s_ren) begin
      ren_cnt++;
      if (first_ren < 0) first_ren = cyc;
      last_ren = cyc;
      if (!s_rst && fq.size() > 0) pipe.push_back('{d: fq[0], c: cyc});
    end
    if (s_inj && !s_rst) err_exp = 1'b1;
    if (s_rst) begin
      pipe.delete();
      err_exp = 1'b0; words_m = 0; stalls_m = 0;
    end
    cyc++;
    @(posedge clk); #1;
    if (s_ren && fq.size() > 0) begin
      fifo_r_data = fq.pop_front(); fifo_r_data_valid = 1'b1; inj_cur = 1'b0;
    end else if (inject_req) begin
      fifo_r_data = 9'h1A5; fifo_r_data_valid = 1'b1; inj_cur = 1'b1; inject_req = 1'b0;
    end else begin
      fifo_r_data_valid = 1'b0; inj_cur = 1'b0;
    end
    if (wr_left > 0 && $urandom_range(0, 2) != 0) begin
      logic [8:0] w;
      w = 9'($urandom_range(0, 511));
      fq.push_back(w); in_q.push_back(w); wr_left--;
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; m_ready = 1'b0;
    step();
    rst = 1'b0;
    fq.delete(); in_q.delete(); out_q.delete();
    fifo_empty = 1'b1; wr_left = 0;
    ren_cnt = 0; first_ren = -1; last_ren = -1; first_vld = -1;
  endtask

  task automatic preload(input int n, input logic [8:0] base);
    for (int i = 0; i < n; i++) begin
      fq.push_back(base + 9'(i)); in_q.push_back(base + 9'(i));
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic cmp_order(input string nm);
    chk({nm, "_len"}, out_q.size(), in_q.size());
    for (int i = 0; i < in_q.size() && i < out_q.size(); i++) chk(nm, out_q[i], in_q[i]);
  endtask

  initial begin
    int b, k;
    rst = 1'b1; enable = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1;
    fifo_r_data_valid = 1'b0; fifo_r_data = '0;
    do_reset();
    step();
    chk("rst_m_valid", s_vld, 0);
    chk("rst_m_data", s_dat, 0);
    chk("rst_idle", s_idle, 1);
    chk("rst_err", s_err, 0);
    chk("rst_r_en", s_ren, 0);
    chk("rst_stat_words", s_words, 0);

    // throughput: 100 words, always ready
    do_reset();
    preload(100, 9'h001);
    enable = 1'b1; m_ready = 1'b1;
    b = 0;
    while (out_q.size() < 100 && b < 400) begin step(); b++; end
    cmp_order("thr_order");
    chk("thr_first", out_q[0], 9'h001);
    chk("thr_last", out_q[99], 9'h064);
    chk("thr_ren_cnt", ren_cnt, 100);
    chk("thr_ren_contig", last_ren - first_ren + 1, 100);
    chk("thr_latency", first_vld - first_ren, 2);
    chk("thr_err", s_err, 0);

    // back-pressure: 10 stall cycles with valid data held
    do_reset();
    preload(4, 9'h0A0);
    enable = 1'b1; m_ready = 1'b0;
    k = 0; b = 0;
    while (k < 10 && b < 40) begin
      step(); b++;
      if (s_vld) begin k++; chk("bp_hold", s_dat, 9'h0A0); end
    end
    chk("bp_stall_seen", k, 10);
    chk("bp_ren_cnt", ren_cnt, 2);
    m_ready = 1'b1;
    b = 0;
    while (out_q.size() < 4 && b < 30) begin step(); b++; end
    step();
    cmp_order("bp_order");
`ifdef FIFO_READER_STATS_EN
    chk("bp_stat_stalls", s_stalls, 10);
    chk("bp_stat_words", s_words, 4);
`else
    chk("bp_stat_stalls", s_stalls, 0);
`endif

    // random writes and random ready
    do_reset();
    enable = 1'b1; wr_left = 100;
    b = 0;
    while (out_q.size() < 100 && b < 3000) begin
      m_ready = 1'($urandom_range(0, 1));
      step(); b++;
    end
    cmp_order("rnd_order");

    // drain: enable drops in the first RUN cycle
    do_reset();
    preload(6, 9'h100);
    enable = 1'b1; m_ready = 1'b1;
    step();
    enable = 1'b0;
    step();
    chk("drain_ren", s_ren, 1);
    b = 0;
    do begin step(); b++; end while (!s_idle && b < 20);
    chk("drain_idle", s_idle, 1);
    chk("drain_word", out_q[0], 9'h100);
    chk("drain_out_cnt", out_q.size(), 1);
    repeat (3) step();
    chk("drain_no_ren", ren_cnt, 1);
    chk("drain_fifo_left", fq.size(), 5);

    // unsolicited read data
    do_reset();
    inject_req = 1'b1;
    step();
    step();
    step();
    chk("err_set", s_err, 1);
    chk("err_no_word", s_vld, 0);
    repeat (3) step();
    chk("err_sticky", s_err, 1);
    do_reset();
    step();
    chk("err_clear", s_err, 0);

    // reset with two buffered words and a read going out on the reset edge
    do_reset();
    preload(4, 9'h050);
    enable = 1'b1; m_ready = 1'b0;
    repeat (6) step();
    chk("rm_buffered", s_vld, 1);
    m_ready = 1'b1; rst = 1'b1; enable = 1'b0;
    step();
    chk("rm_ren_at_rst", s_ren, 1);
    rst = 1'b0;
    step();
    chk("rm_m_valid", s_vld, 0);
    chk("rm_idle", s_idle, 1);
    repeat (3) step();
    chk("rm_late_word", s_vld, 0);
    chk("rm_err", s_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
